// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token constants, token lookup and the
// receive alignment state type. Used by both the encoder and the decoder.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_0 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_1 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_2 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_3 = 10'b1010101011;

  typedef enum logic {
    SEARCH,
    LOCKED
  } tmds_state_e;

  typedef struct packed {
    logic       is_token;
    logic [1:0] control;
  } token_match_t;

  // Maps a symbol to its {vsync, hsync} value; is_token is 0 for data symbols.
  function automatic token_match_t token_to_control(input logic [9:0] symbol);
    token_match_t match;
    match.is_token = 1'b1;
    match.control  = 2'b00;
    case (symbol)
      CTRL_TOKEN_0: match.control = 2'b00;
      CTRL_TOKEN_1: match.control = 2'b01;
      CTRL_TOKEN_2: match.control = 2'b10;
      CTRL_TOKEN_3: match.control = 2'b11;
      default:      match.is_token = 1'b0;
    endcase
    return match;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into token flag,
// control value and 8-bit pixel data.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] symbol,
  output logic       is_token,
  output logic [1:0] control,
  output logic [7:0] data
);

  token_match_t match;
  logic [7:0]   d;

  always_comb begin
    match    = token_to_control(symbol);
    is_token = match.is_token;
    control  = match.control;
    d        = symbol[9] ? ~symbol[7:0] : symbol[7:0];
    data     = '0;
    data[0]  = d[0];
    // bit 8 selects XOR vs XNOR chaining used by the encoder
    for (int unsigned i = 1; i < 8; i++) begin
      data[i] = symbol[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// Single-channel TMDS receive decoder: bit-slip alignment on control-token
// runs, then registered decode of each accepted symbol.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned p_lock_count     = 8,
  parameter int unsigned p_search_timeout = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [9:0] i_word,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic [1:0] o_control_data,
  output logic       o_blank,
  output logic       o_locked,
  output logic [3:0] o_offset,
  output logic       o_err
);

  localparam int unsigned RUN_W   = $clog2(p_lock_count + 1);
  localparam int unsigned TIMER_W = $clog2(p_search_timeout);
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(p_lock_count - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(p_search_timeout - 1);

  tmds_state_e        state;
  logic [9:0]         prev_word;
  logic [RUN_W-1:0]   run_cnt;
  logic [TIMER_W-1:0] timer;
  logic [19:0]        window;
  logic [9:0]         symbol;
  logic               sym_is_token;
  logic [1:0]         sym_control;
  logic [7:0]         sym_data;

  // Bit 0 of prev_word is earliest, so offset N drops the N oldest bits.
  always_comb begin
    window = {i_word, prev_word};
    symbol = 10'(window >> o_offset);
  end

  tmds_symbol_decode u_symbol_decode (
    .symbol   (symbol),
    .is_token (sym_is_token),
    .control  (sym_control),
    .data     (sym_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= SEARCH;
      prev_word      <= '0;
      run_cnt        <= '0;
      timer          <= '0;
      o_valid        <= 1'b0;
      o_data         <= '0;
      o_control_data <= '0;
      o_blank        <= 1'b0;
      o_locked       <= 1'b0;
      o_offset       <= '0;
      o_err          <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (i_valid) begin
        prev_word <= i_word;
        o_blank   <= sym_is_token;
        o_data    <= sym_is_token ? '0 : sym_data;
        if (sym_is_token) o_control_data <= sym_control;
        case (state)
          SEARCH: begin
            if (sym_is_token) begin
              timer <= '0;
              if (run_cnt == RUN_LAST) begin
                state    <= LOCKED;
                run_cnt  <= '0;
                o_locked <= 1'b1;
                o_valid  <= 1'b1;
              end else begin
                run_cnt <= run_cnt + 1'b1;
              end
            end else begin
              run_cnt <= '0;
              if (timer == TIMER_LAST) begin
                timer    <= '0;
                o_offset <= (o_offset == 4'd9) ? 4'd0 : o_offset + 4'd1;
              end else begin
                timer <= timer + 1'b1;
              end
            end
          end
          LOCKED: begin
            o_valid <= 1'b1;
            if (sym_is_token) begin
              timer <= '0;
            end else if (timer == TIMER_LAST) begin
              state    <= SEARCH;
              o_locked <= 1'b0;
              o_err    <= 1'b1;
              timer    <= '0;
              run_cnt  <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
